// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Shared processor definitions for the writeback stage:
//               default geometry, the writeback FSM state encoding and
//               the vector register type (LANES_DEFAULT x DW_DEFAULT).
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

    localparam int LANES_DEFAULT       = 20;
    localparam int DW_DEFAULT          = 8;
    localparam int RA_W_DEFAULT        = 3;
    localparam int MEM_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

    // One vector register: lane 0 occupies the least significant element.
    typedef logic [LANES_DEFAULT-1:0][DW_DEFAULT-1:0] vec_t;

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/writeback_stage_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Memory wait watchdog. Counts cycles spent waiting for memory
//               and flags expiry on the cycle the count reaches
//               MEM_TIMEOUT-1.
// Ports       : clk       - clock
//               rst       - asynchronous active-low reset
//               i_clear   - restart the count (entry to the wait state)
//               i_enable  - one more cycle waited without completion
//               o_expired - this waiting cycle is the timeout cycle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter
    import writeback_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    // The count that would become MEM_TIMEOUT-1 with this cycle's increment.
    localparam logic [CW-1:0] C_LAST = CW'(MEM_TIMEOUT - 2);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Expiry is qualified by enable, so a completion strobe on the same
    // cycle always wins.
    assign o_expired = i_enable && (r_count == C_LAST);

endmodule : wb_timeout_counter
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Pipeline writeback stage. Accepts an instruction leaving the
//               memory stage, waits for memory completion when needed, then
//               issues a single-cycle scalar or vector register file write.
//               A memory wait that exceeds MEM_TIMEOUT sets a sticky error.
// Ports       : clk, rst (async active-low)
//               in_valid, mem_access, mem_finished, mem_to_reg, op_type,
//               reg_write, rd, scalar_output, mem_data, vector_output (in)
//               we_sca, we_vec, wa, wd_sca, wd_vec, stall, wb_error,
//               retired_count (out)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int LANES       = LANES_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int RA_W        = RA_W_DEFAULT,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      mem_access,
    input  logic                      mem_finished,
    input  logic                      mem_to_reg,
    input  logic                      op_type,
    input  logic                      reg_write,
    input  logic [RA_W-1:0]           rd,
    input  logic [DW-1:0]             scalar_output,
    input  logic [DW-1:0]             mem_data,
    input  logic [LANES-1:0][DW-1:0]  vector_output,
    output logic                      we_sca,
    output logic                      we_vec,
    output logic [RA_W-1:0]           wa,
    output logic [DW-1:0]             wd_sca,
    output logic [LANES-1:0][DW-1:0]  wd_vec,
    output logic                      stall,
    output logic                      wb_error,
    output logic [15:0]               retired_count
);

    wb_state_t r_state;
    wb_state_t w_next_state;

    logic                     r_reg_write;
    logic                     r_op_type;
    logic                     r_mem_to_reg;
    logic [RA_W-1:0]          r_rd;
    logic [DW-1:0]            r_wd_sca;
    logic [LANES-1:0][DW-1:0] r_wd_vec;
    logic [15:0]              r_retired;
    logic                     r_wb_error;

    logic w_accept;
    logic w_enter_wait;
    logic w_wait_done;
    logic w_wait_tick;
    logic w_expired;

    // A new instruction is only taken when not already waiting on memory.
    assign w_accept     = in_valid && (r_state != ST_WAIT_MEM);
    assign w_enter_wait = w_accept && mem_access && !mem_finished;
    assign w_wait_done  = (r_state == ST_WAIT_MEM) && mem_finished;
    assign w_wait_tick  = (r_state == ST_WAIT_MEM) && !mem_finished;

    wb_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_enter_wait),
        .i_enable  (w_wait_tick),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (w_accept) begin
                    w_next_state = w_enter_wait ? ST_WAIT_MEM : ST_WRITE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_finished) begin
                    w_next_state = ST_WRITE;
                end else if (w_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Write data is captured straight into the output registers on the edge
    // that enters WRITE (from the accept cycle or from memory completion), so
    // wd_sca/wd_vec carry the captured values during WRITE and naturally
    // hold them afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_reg_write  <= 1'b0;
            r_op_type    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_rd         <= '0;
            r_wd_sca     <= '0;
            r_wd_vec     <= '0;
            r_retired    <= '0;
            r_wb_error   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_reg_write  <= reg_write;
                r_op_type    <= op_type;
                r_mem_to_reg <= mem_to_reg;
                r_rd         <= rd;
            end

            if (w_accept && !w_enter_wait) begin
                r_wd_sca <= mem_to_reg ? mem_data : scalar_output;
                r_wd_vec <= vector_output;
            end else if (w_wait_done) begin
                r_wd_sca <= r_mem_to_reg ? mem_data : scalar_output;
                r_wd_vec <= vector_output;
            end

            if (r_state == ST_WRITE) begin
                r_retired <= r_retired + 16'd1;
            end

            if (w_expired) begin
                r_wb_error <= 1'b1;
            end
        end
    end

    assign we_sca        = (r_state == ST_WRITE) && r_reg_write && !r_op_type;
    assign we_vec        = (r_state == ST_WRITE) && r_reg_write && r_op_type;
    assign wa            = r_rd;
    assign wd_sca        = r_wd_sca;
    assign wd_vec        = r_wd_vec;
    assign stall         = (r_state == ST_WAIT_MEM);
    assign wb_error      = r_wb_error;
    assign retired_count = r_retired;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, mem_access, mem_finished, mem_to_reg;
    logic             op_type, reg_write;
    logic [2:0]       rd;
    logic [7:0]       scalar_output, mem_data;
    logic [19:0][7:0] vector_output;
    logic             we_sca, we_vec, stall, wb_error;
    logic [2:0]       wa;
    logic [7:0]       wd_sca;
    logic [19:0][7:0] wd_vec;
    logic [15:0]      retired_count;

    logic [19:0][7:0] exp_vec;
    int               vectors     = 0;
    int               miscompares = 0;
    int               stall_cycles;
    int               bad_we;

    writeback_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .mem_access    (mem_access),
        .mem_finished  (mem_finished),
        .mem_to_reg    (mem_to_reg),
        .op_type       (op_type),
        .reg_write     (reg_write),
        .rd            (rd),
        .scalar_output (scalar_output),
        .mem_data      (mem_data),
        .vector_output (vector_output),
        .we_sca        (we_sca),
        .we_vec        (we_vec),
        .wa            (wa),
        .wd_sca        (wd_sca),
        .wd_vec        (wd_vec),
        .stall         (stall),
        .wb_error      (wb_error),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set after this are sampled on the next edge
    // and outputs read after this reflect the state just entered.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        mem_access    = 1'b0;
        mem_finished  = 1'b0;
        mem_to_reg    = 1'b0;
        op_type       = 1'b0;
        reg_write     = 1'b0;
        rd            = '0;
        scalar_output = '0;
        mem_data      = '0;
        vector_output = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #12;
        check("reset_we_sca", 256'(we_sca), 256'(0));
        check("reset_we_vec", 256'(we_vec), 256'(0));
        check("reset_stall", 256'(stall), 256'(0));
        check("reset_wd_vec", 256'(wd_vec), 256'(0));
        check("reset_retired", 256'(retired_count), 256'(0));
        check("reset_error", 256'(wb_error), 256'(0));
        step();

        // Scalar ALU op, presented with reset release: first edge accepts.
        rst = 1'b1;
        in_valid = 1'b1; reg_write = 1'b1; rd = 3'd3; scalar_output = 8'd42;
        step();
        idle_inputs();
        check("alu_we_sca", 256'(we_sca), 256'(1));
        check("alu_we_vec", 256'(we_vec), 256'(0));
        check("alu_wa", 256'(wa), 256'(3));
        check("alu_wd_sca", 256'(wd_sca), 256'(42));
        check("alu_stall", 256'(stall), 256'(0));
        step();
        check("alu_we_off", 256'(we_sca), 256'(0));
        check("alu_retired", 256'(retired_count), 256'(1));
        check("alu_wd_hold", 256'(wd_sca), 256'(42));

        // Vector load: four wait cycles, completion on the fourth; inputs
        // offered while waiting must be ignored.
        in_valid = 1'b1; mem_access = 1'b1; op_type = 1'b1; reg_write = 1'b1;
        rd = 3'd5; vector_output = '1;
        step();
        for (int i = 1; i <= 4; i++) begin
            check("vld_stall", 256'(stall), 256'(1));
            check("vld_no_we", 256'({we_sca, we_vec}), 256'(0));
            in_valid = (i < 4); mem_access = 1'b0; rd = 3'd7;
            mem_finished = (i == 4);
            if (i == 4) begin
                for (int l = 0; l < 20; l++) vector_output[l] = 8'(50 + l);
            end
            step();
        end
        idle_inputs();
        for (int l = 0; l < 20; l++) exp_vec[l] = 8'(50 + l);
        check("vld_we_vec", 256'(we_vec), 256'(1));
        check("vld_we_sca", 256'(we_sca), 256'(0));
        check("vld_wa", 256'(wa), 256'(5));
        check("vld_wd_vec", 256'(wd_vec), 256'(exp_vec));
        check("vld_stall_low", 256'(stall), 256'(0));
        step();
        check("vld_retired", 256'(retired_count), 256'(2));
        check("vld_wd_vec_hold", 256'(wd_vec), 256'(exp_vec));

        // Scalar load completing on the accept cycle.
        in_valid = 1'b1; mem_access = 1'b1; mem_finished = 1'b1; mem_to_reg = 1'b1;
        reg_write = 1'b1; rd = 3'd2; mem_data = 8'd117; scalar_output = 8'd9;
        step();
        idle_inputs();
        check("sld_we_sca", 256'(we_sca), 256'(1));
        check("sld_wa", 256'(wa), 256'(2));
        check("sld_wd_sca", 256'(wd_sca), 256'(117));
        check("sld_stall", 256'(stall), 256'(0));
        step();
        check("sld_retired", 256'(retired_count), 256'(3));

        // Store followed back-to-back by an ALU op.
        in_valid = 1'b1; mem_access = 1'b1; mem_finished = 1'b1; rd = 3'd6;
        scalar_output = 8'd77;
        step();
        idle_inputs();
        in_valid = 1'b1; reg_write = 1'b1; rd = 3'd4; scalar_output = 8'd99;
        check("st_no_we", 256'({we_sca, we_vec}), 256'(0));
        check("st_stall", 256'(stall), 256'(0));
        step();
        idle_inputs();
        check("st_alu_we_sca", 256'(we_sca), 256'(1));
        check("st_alu_wa", 256'(wa), 256'(4));
        check("st_alu_wd_sca", 256'(wd_sca), 256'(99));
        check("st_alu_retired_mid", 256'(retired_count), 256'(4));
        step();
        check("st_retired_plus2", 256'(retired_count), 256'(5));

        // Completion on the timeout cycle wins: 63 stalled cycles, then a write.
        in_valid = 1'b1; mem_access = 1'b1; reg_write = 1'b1; rd = 3'd1; mem_data = 8'd200;
        mem_to_reg = 1'b1;
        step();
        idle_inputs();
        for (int c = 1; c <= 63; c++) begin
            if (c == 63) begin
                mem_finished = 1'b1; mem_data = 8'd201;
            end
            step();
        end
        idle_inputs();
        check("prio_we_sca", 256'(we_sca), 256'(1));
        check("prio_wd_sca", 256'(wd_sca), 256'(201));
        check("prio_no_error", 256'(wb_error), 256'(0));
        step();
        check("prio_retired", 256'(retired_count), 256'(6));

        // Memory never finishes: exactly 63 stalled cycles, then error.
        in_valid = 1'b1; mem_access = 1'b1; reg_write = 1'b1; rd = 3'd1;
        step();
        idle_inputs();
        stall_cycles = 0;
        bad_we = 0;
        check("to_error_low", 256'(wb_error), 256'(0));
        for (int c = 0; c < 100 && stall; c++) begin
            stall_cycles++;
            if (we_sca || we_vec) bad_we++;
            step();
        end
        check("to_stall_cycles", 256'(stall_cycles), 256'(63));
        check("to_no_write", 256'(bad_we), 256'(0));
        check("to_error", 256'(wb_error), 256'(1));
        check("to_we_after", 256'({we_sca, we_vec}), 256'(0));
        check("to_retired", 256'(retired_count), 256'(6));
        step();
        step();
        check("to_error_sticky", 256'(wb_error), 256'(1));
        check("to_retired_hold", 256'(retired_count), 256'(6));

        // Reset asserted on the second wait cycle aborts the instruction.
        in_valid = 1'b1; mem_access = 1'b1; op_type = 1'b1; reg_write = 1'b1; rd = 3'd5;
        step();
        idle_inputs();
        step();
        check("rst_pre_stall", 256'(stall), 256'(1));
        #1 rst = 1'b0;
        #1;
        check("rst_async_stall", 256'(stall), 256'(0));
        check("rst_async_we", 256'({we_sca, we_vec}), 256'(0));
        check("rst_async_wa", 256'(wa), 256'(0));
        check("rst_async_wd_vec", 256'(wd_vec), 256'(0));
        check("rst_async_retired", 256'(retired_count), 256'(0));
        check("rst_async_error", 256'(wb_error), 256'(0));
        #1 rst = 1'b1;
        mem_finished = 1'b1;
        bad_we = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (we_sca || we_vec || stall) bad_we++;
        end
        check("rst_no_late_write", 256'(bad_we), 256'(0));
        check("rst_retired_zero", 256'(retired_count), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameters LANES=20 (vector lanes), DW=8 (element width), RA_W=3 (register index width) and MEM_TIMEOUT=64 (maximum cycles to wait for memory).
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  an instruction leaving the memory stage is presented this cycle.
- mem_access  input  1  the instruction is a load or a store.
- mem_finished  input  1  memory stage completion strobe.
- mem_to_reg  input  1  scalar writeback source: 1 selects mem_data, 0 selects scalar_output.
- op_type  input  1  0 = scalar, 1 = vector.
- reg_write  input  1  the instruction writes a destination register.
- rd  input  RA_W  destination register index.
- scalar_output  input  DW  scalar result from the memory stage.
- mem_data  input  DW  scalar load data.
- vector_output  input  LANES x DW  vector result or vector load data.
- we_sca  output  1  scalar register file write enable.
- we_vec  output  1  vector register file write enable.
- wa  output  RA_W  write address.
- wd_sca  output  DW  scalar write data.
- wd_vec  output  LANES x DW  vector write data.
- stall  output  1  upstream SHALL hold its instruction while this is high.
- wb_error  output  1  sticky memory-timeout flag.
- retired_count  output  16  number of retired instructions.

Function
REQ-003 SHALL implement an FSM with states IDLE, WAIT_MEM and WRITE.
REQ-004 in_valid is sampled only in IDLE or WRITE; while in WAIT_MEM, in_valid SHALL be ignored.
REQ-005 On acceptance, SHALL capture all control and data inputs into internal registers.
REQ-006 Acceptance with mem_access=0, or with mem_access=1 and mem_finished=1 in the same cycle: next state SHALL be WRITE, giving one-cycle latency.
REQ-007 Acceptance with mem_access=1 and mem_finished=0: next state SHALL be WAIT_MEM.
REQ-008 In WAIT_MEM, when mem_finished=1:
- SHALL recapture scalar_output, mem_data and vector_output;
- SHALL go to WRITE.
REQ-009 stall SHALL equal (state==WAIT_MEM) and SHALL be combinational from the state register.
REQ-010 In WRITE, the enables SHALL be driven for exactly one cycle:
- we_sca = reg_write & ~op_type;
- we_vec = reg_write & op_type;
- wa = captured rd.
REQ-011 Write data SHALL be:
- wd_sca = mem_to_reg ? mem_data : scalar_output;
- wd_vec = vector_output;
- both from captured values.
- Both data outputs SHALL hold their last value outside WRITE.
REQ-012 A store (mem_access=1, reg_write=0) SHALL pass through WRITE with both enables low.
REQ-013 In WRITE:
- with a new acceptance, SHALL follow REQ-006 or REQ-007 (back-to-back, no bubble);
- otherwise SHALL go to IDLE.
REQ-014 retired_count SHALL increment by 1 in every WRITE cycle and SHALL wrap from 0xFFFF to 0.
REQ-015 A wait counter SHALL clear on entry to WAIT_MEM and increment each WAIT_MEM cycle without mem_finished.
REQ-016 If the wait counter reaches MEM_TIMEOUT-1 without mem_finished, on that cycle the block SHALL:
- go to IDLE;
- set wb_error;
- perform no write;
- leave retired_count unchanged.
REQ-017 mem_finished on the timeout cycle SHALL take priority: normal transition to WRITE, no error.
REQ-018 wb_error SHALL stay set until reset.

Reset
REQ-019 On rst low, asynchronously:
- state = IDLE;
- all outputs 0 (including wd_vec and retired_count);
- wb_error = 0;
- wait counter = 0;
- captured registers = 0.
REQ-020 Reset during WAIT_MEM or WRITE SHALL abort the instruction, so no write enable is asserted after rst falls.
REQ-021 The first acceptance SHALL occur on the first rising clk edge with rst high.

Structure
REQ-022 The FSM state enum and the LANES, DW, RA_W and MEM_TIMEOUT defaults SHALL live in the shared processor package; the vector type (LANES x DW) SHALL be defined there.
REQ-023 A single sub-module, wb_timeout_counter (clear, enable, expired), SHALL implement REQ-015 and REQ-016; everything else SHALL be flat.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Scalar ALU op: in_valid=1, mem_access=0, reg_write=1, op_type=0, rd=3, scalar_output=8'd42 -> next cycle we_sca=1, wa=3, wd_sca=42, stall never high, retired_count=1.
- Vector load: mem_access=1, op_type=1, rd=5, mem_finished low 4 cycles with vector_output lanes 50..69 -> stall high 4 cycles; then one cycle we_vec=1, wa=5, wd_vec lane0=50 ... lane19=69.
- Scalar load with mem_to_reg=1, mem_data=8'd117, mem_finished high on the accept cycle -> one-cycle latency, we_sca=1, wd_sca=117.
- Store (reg_write=0) followed back-to-back by an ALU op -> a WRITE cycle with no enables, then the ALU write on the next cycle, retired_count +2, no bubble.
- mem_finished never asserted -> stall high exactly 63 cycles, then wb_error=1, no write, retired_count unchanged.
- rst low during WAIT_MEM (cycle 2) -> outputs immediately 0, state IDLE, later mem_finished produces no write.
